sys_mem_rmw: RTL and testbench

Parametrised byte-lane system memory controller, the successor of the fixed 64x8 system memory. It stores WORDS words of LANES lanes each, and is accessed one lane (byte) per request through a valid/ready handshake. Writes are performed as read-modify-write on the containing word. A multi-cycle erase sweep clears the array, and the sweep also runs automatically after reset. It sits between the system bus decoder and the processing core as the general-purpose scratch store.

---
 rtl/sys_mem_pkg.sv | 28 ++
 rtl/sys_mem_array.sv | 36 +++
 rtl/sys_mem_rmw.sv | 191 +++++++++++++++++++
 tb/tb_sys_mem_rmw.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sys_mem_pkg.sv
// sys_mem_pkg: shared FSM state encoding, default geometry and word type for
// the byte-lane read-modify-write system memory.
// Optional parity storage is enabled by defining SYS_MEM_PAR_EN.
package sys_mem_pkg;

    // Default geometry: 64 lanes of 8 bits, grouped 4 lanes per word
    localparam int SYS_ADDR_W = 6;
    localparam int SYS_LANE_W = 8;
    localparam int SYS_LANES  = 4;

    // Derived constants for the default geometry
    localparam int LANE_SEL_W = $clog2(SYS_LANES);
    localparam int WORD_W     = SYS_LANES * SYS_LANE_W;
    localparam int WORDS      = (2 ** SYS_ADDR_W) / SYS_LANES;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [2:0] {
        ST_ERASE    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_RD_WORD  = 3'd2,
        ST_RD_OUT   = 3'd3,
        ST_WR_WORD  = 3'd4,
        ST_WR_MERGE = 3'd5,
        ST_WR_BACK  = 3'd6
    } state_t;

endpackage

// File: rtl/sys_mem_array.sv
// sys_mem_array: word-wide storage with one registered read port and one
// synchronous write port. No reset: contents are cleared by the controller's
// erase sweep. When SYS_MEM_PAR_EN is defined the controller widens DATA_W to
// carry the per-lane parity bits alongside the data.
module sys_mem_array
    import sys_mem_pkg::*;
#(
    parameter int WORDS_N = WORDS,
    parameter int DATA_W  = WORD_W,
    parameter int IDX_W   = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i
);

    logic [DATA_W-1:0] mem_q [WORDS_N];
    logic [DATA_W-1:0] rd_q;

    // Synchronous write and registered read; read returns the pre-write value
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/sys_mem_rmw.sv
// sys_mem_rmw: byte-lane memory controller. Single-lane reads and writes via a
// valid/ready handshake; writes are read-modify-write of the containing word.
// An erase sweep zeroes the array after reset and on erase_req.
// Define SYS_MEM_PAR_EN to store one even-parity bit per lane and report
// mismatches on rsp_err; otherwise rsp_err is tied low.
module sys_mem_rmw
    import sys_mem_pkg::*;
#(
    parameter int ADDR_W = SYS_ADDR_W,
    parameter int LANE_W = SYS_LANE_W,
    parameter int LANES  = SYS_LANES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANE_W-1:0] req_data,
    input  logic              erase_req,
    output logic              busy,
    output logic              rsp_valid,
    output logic [LANE_W-1:0] rsp_data,
    output logic              rsp_err
);

    localparam int LSEL_W  = $clog2(LANES);
    localparam int WRD_W   = LANES * LANE_W;
    localparam int N_WORDS = (2 ** ADDR_W) / LANES;
    localparam int WIDX_W  = ADDR_W - LSEL_W;
`ifdef SYS_MEM_PAR_EN
    localparam int ST_W    = WRD_W + LANES;   // parity bits sit above the data
`else
    localparam int ST_W    = WRD_W;
`endif

    state_t              state_q, state_d;
    logic [WIDX_W-1:0]   sweep_q, sweep_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LANE_W-1:0]   wdata_q, wdata_d;
    logic [ST_W-1:0]     merged_q, merged_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [LANE_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef SYS_MEM_PAR_EN
    logic                rsp_err_q, rsp_err_d;
`endif

    logic                arr_rd_en;
    logic [ST_W-1:0]     arr_rd_data;
    logic                arr_wr_en;
    logic [WIDX_W-1:0]   arr_wr_addr;
    logic [ST_W-1:0]     arr_wr_data;

    logic [WIDX_W-1:0]   word_idx;
    logic [LSEL_W-1:0]   lane;
    logic [LANE_W-1:0]   rd_lane;

    assign word_idx = addr_q[ADDR_W-1:LSEL_W];
    assign lane     = addr_q[LSEL_W-1:0];
    assign rd_lane  = arr_rd_data[lane*LANE_W +: LANE_W];

    sys_mem_array #(
        .WORDS_N (N_WORDS),
        .DATA_W  (ST_W),
        .IDX_W   (WIDX_W)
    ) u_array (
        .clk       (clk),
        .rd_en_i   (arr_rd_en),
        .rd_addr_i (word_idx),
        .rd_data_o (arr_rd_data),
        .wr_en_i   (arr_wr_en),
        .wr_addr_i (arr_wr_addr),
        .wr_data_i (arr_wr_data)
    );

    // State and datapath registers; reset aborts any operation and restarts the sweep
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ERASE;
            sweep_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            merged_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
`ifdef SYS_MEM_PAR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            merged_q    <= merged_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
`ifdef SYS_MEM_PAR_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Next-state, array control and lane merge
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merged_d    = merged_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
`ifdef SYS_MEM_PAR_EN
        rsp_err_d   = rsp_err_q;
`endif
        arr_rd_en   = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_addr = word_idx;
        arr_wr_data = merged_q;

        case (state_q)
            ST_ERASE: begin
                // Zero data with zero parity is a valid even-parity word
                arr_wr_en   = 1'b1;
                arr_wr_addr = sweep_q;
                arr_wr_data = '0;
                if (sweep_q == WIDX_W'(N_WORDS - 1)) begin
                    sweep_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    sweep_d = sweep_q + WIDX_W'(1);
                end
            end
            ST_IDLE: begin
                // Erase wins over a simultaneous request (ready is low then)
                if (erase_req) begin
                    sweep_d = '0;
                    state_d = ST_ERASE;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_data;
                    state_d = req_write ? ST_WR_WORD : ST_RD_WORD;
                end
            end
            ST_RD_WORD: begin
                arr_rd_en = 1'b1;
                state_d   = ST_RD_OUT;
            end
            ST_RD_OUT: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = rd_lane;
`ifdef SYS_MEM_PAR_EN
                rsp_err_d   = (^rd_lane) != arr_rd_data[WRD_W + 32'(lane)];
`endif
                state_d     = ST_IDLE;
            end
            ST_WR_WORD: begin
                arr_rd_en = 1'b1;
                state_d   = ST_WR_MERGE;
            end
            ST_WR_MERGE: begin
                merged_d = arr_rd_data;
                merged_d[lane*LANE_W +: LANE_W] = wdata_q;
`ifdef SYS_MEM_PAR_EN
                for (int l = 0; l < LANES; l++) begin
                    merged_d[WRD_W + l] = ^merged_d[l*LANE_W +: LANE_W];
                end
`endif
                state_d = ST_WR_BACK;
            end
            ST_WR_BACK: begin
                arr_wr_en = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                sweep_d = '0;
                state_d = ST_ERASE;
            end
        endcase
    end

    assign req_ready = (state_q == ST_IDLE) & ~erase_req;
    assign busy      = (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
`ifdef SYS_MEM_PAR_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sys_mem_rmw.sv
// tb_sys_mem_rmw: directed plus randomized checks of sys_mem_rmw against a
// plain lane-array model. Parity fault injection runs when SYS_MEM_PAR_EN is defined.
module tb_sys_mem_rmw;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_write = 1'b0;
    logic [5:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       erase_req = 1'b0;
    logic       busy;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] model [64];

    sys_mem_rmw #(.ADDR_W(6), .LANE_W(8), .LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .erase_req (erase_req),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (%0d vectors)", vectors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 64; i++) model[i] = 8'h00;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (req_ready !== 1'b1) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] ed, input logic ee);
        wait_ready("rd");
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_data = 8'($urandom);
        step();                                   // accepted at this edge (E0)
        req_valid = 1'b0;
        chk("rd_e0_valid", 32'(rsp_valid), 32'd0);
        chk("rd_e0_busy", 32'(busy), 32'd1);
        step();                                   // E1
        chk("rd_e1_valid", 32'(rsp_valid), 32'd0);
        chk("rd_e1_ready", 32'(req_ready), 32'd0);
        step();                                   // E2
        chk("rd_valid", 32'(rsp_valid), 32'd1);
        chk("rd_data", 32'(rsp_data), 32'(ed));
        chk("rd_err", 32'(rsp_err), 32'(ee));
        chk("rd_ready_after", 32'(req_ready), 32'd1);
        step();
        chk("rd_pulse_end", 32'(rsp_valid), 32'd0);
        chk("rd_data_held", 32'(rsp_data), 32'(ed));
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wait_ready("wr");
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d;
        step();                                   // accepted at E0
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("wr_ready_low", 32'(req_ready), 32'd0);
            step();
        end
        chk("wr_ready_after", 32'(req_ready), 32'd1);
        model[a] = d;
    endtask

    initial begin
        logic [7:0] d;
        logic [5:0] a;

        // Reset values
        clear_model();
        repeat (3) step();
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);

        // Post-reset sweep: busy for exactly 16 cycles
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("sweep_ready", 32'(req_ready), 32'(i == 16));
            chk("sweep_busy", 32'(busy), 32'(i != 16));
        end
        rd(6'h2A, 8'h00, 1'b0);

        // Lane merge within word 1
        wr(6'h05, 8'hA5);
        wr(6'h06, 8'h3C);
        for (int i = 4; i < 8; i++) rd(6'(i), model[i], 1'b0);

        // Erase priority over a simultaneous write
        wait_ready("erase");
        erase_req = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h10; req_data = 8'hFF;
        #1;
        chk("erase_prio_ready", 32'(req_ready), 32'd0);
        step();                                   // IDLE -> ERASE
        erase_req = 1'b0;
        chk("erase_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk("erase_sweep_ready", 32'(req_ready), 32'(i == 16));
        end
        step();                                   // held write accepted here
        req_valid = 1'b0;
        chk("erase_wr_busy", 32'(busy), 32'd1);
        clear_model();
        model[6'h10] = 8'hFF;
        for (int i = 0; i < 64; i++) rd(6'(i), model[i], 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 150; n++) begin
            a = 6'($urandom_range(0, 63));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) wr(a, d);
            else rd(a, model[a], 1'b0);
        end

        // Reset during WR_MERGE aborts the write
        wait_ready("rstw");
        req_valid = 1'b1; req_write = 1'b1; req_addr = 6'h3F; req_data = 8'h77;
        step();                                   // E0: WR_WORD
        req_valid = 1'b0;
        step();                                   // E1: WR_MERGE
        rst_n = 1'b0;
        #1;
        chk("rstw_busy", 32'(busy), 32'd1);
        step();
        rst_n = 1'b1;
        clear_model();
        rd(6'h3F, 8'h00, 1'b0);

`ifdef SYS_MEM_PAR_EN
        // Parity fault injection in lane 2 of word 1
        wr(6'h05, 8'h22);
        wr(6'h06, 8'h11);
        dut.u_array.mem_q[1][16] = ~dut.u_array.mem_q[1][16];
        rd(6'h06, model[6] ^ 8'h01, 1'b1);
        rd(6'h05, model[5], 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
